mc_hs_controller: RTL and testbench

- Multicycle MIPS control unit, next generation of the fixed-latency controller.
- Adds a req/ready memory handshake with wait states, and a configurable branch set (beq/bne/ble).
- Adds a memory-timeout watchdog and a sticky trap state for illegal opcodes and timeouts.
- Sits between the instruction register (op/funct) and the multicycle datapath; drives every datapath enable/select and the memory request.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_aludec.sv | 31 +++
 rtl/mc_hs_controller.sv | 188 ++++++++++++++++++
 tb/tb_mc_hs_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the handshaked multicycle MIPS controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] BLE   = 6'b000111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BLE  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [1:0] brtype;
  } ctrl_t;

  function automatic logic isMemState(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the R-type funct field to an ALU operation.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alucontrol_o
);

  // Unknown funct codes fall back to add rather than trapping.
  always_comb begin
    alucontrol_o = 4'b0010;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = 4'b0010;
      ALUOP_SUB: alucontrol_o = 4'b0110;
      ALUOP_SLT: alucontrol_o = 4'b0111;
      default: begin
        case (funct_i)
          6'b100000: alucontrol_o = 4'b0010;
          6'b100010: alucontrol_o = 4'b0110;
          6'b100100: alucontrol_o = 4'b0000;
          6'b100101: alucontrol_o = 4'b0001;
          6'b101010: alucontrol_o = 4'b0111;
          6'b101011: alucontrol_o = 4'b1111;
          default:   alucontrol_o = 4'b0010;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_hs_controller.sv
// Multicycle MIPS control FSM with req/ready memory handshake, memory watchdog
// and a sticky trap state for illegal opcodes and memory timeouts.
module mc_hs_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit          EN_BNE      = 1'b1,
  parameter bit          EN_BLE      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        neg,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        pcen,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        alusrca,
  output logic        iord,
  output logic        memtoreg,
  output logic        regdst,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [3:0]  alucontrol,
  output logic [3:0]  state,
  output logic [17:0] controlword,
  output logic        trap,
  output logic [1:0]  err_code
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic [1:0]      err_q, err_d;
  ctrl_t           cw;
  logic            waitCycle;
  logic            timeout;
  logic            pcwriteG;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wdog_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // The watchdog counts stalled memory cycles; any state change clears it.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wdog_d    = '0;
    timeout   = 1'b0;
    waitCycle = isMemState(state_q) && !mem_ready;
    if (waitCycle) begin
      wdog_d  = wdog_q + 1'b1;
      timeout = (MEM_TIMEOUT != 0) && (wdog_d == TO_W'(MEM_TIMEOUT));
    end

    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          LW, SW:  state_d = S_MEMADR;
          RTYPE:   state_d = S_RTYPEEX;
          ADDI:    state_d = S_ADDIEX;
          J:       state_d = S_JEX;
          BEQ:     state_d = S_BREX;
          BNE:     state_d = EN_BNE ? S_BREX : S_TRAP;
          BLE:     state_d = EN_BLE ? S_BREX : S_TRAP;
          default: state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) err_d = ERR_ILLEGAL;
      end
      S_MEMADR:  state_d = (op == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BREX:    state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_TRAP;
    endcase

    if (timeout) begin
      state_d = S_TRAP;
      err_d   = ERR_TIMEOUT;
      wdog_d  = '0;
    end
  end

  // Ungated control table; TRAP and unused encodings fall through to all-zero.
  always_comb begin
    cw = '0;
    case (state_q)
      S_FETCH: begin
        cw.pcwrite = 1'b1;
        cw.irwrite = 1'b1;
        cw.alusrcb = 2'b01;
      end
      S_DECODE:  cw.alusrcb = 2'b11;
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b10;
      end
      S_MEMRD:   cw.iord = 1'b1;
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        cw.memwrite = 1'b1;
        cw.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_BREX: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = 2'b01;
        case (op)
          BEQ:     cw.brtype = BR_BEQ;
          BNE:     cw.brtype = BR_BNE;
          BLE:     cw.brtype = BR_BLE;
          default: cw.brtype = BR_NONE;
        endcase
      end
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = 2'b10;
      end
      S_ADDIWB:  cw.regwrite = 1'b1;
      S_JEX: begin
        cw.pcwrite = 1'b1;
        cw.pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i      (cw.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  // Writes tied to a memory transfer only fire on the cycle the memory completes it.
  assign pcwriteG = cw.pcwrite & ((state_q != S_FETCH) | mem_ready);
  assign irwrite  = cw.irwrite & mem_ready;
  assign memwrite = cw.memwrite & mem_ready;

  assign pcen = pcwriteG
              | ((cw.brtype == BR_BEQ) & zero)
              | ((cw.brtype == BR_BNE) & ~zero)
              | ((cw.brtype == BR_BLE) & (zero | neg));

  assign mem_req     = isMemState(state_q);
  assign regwrite    = cw.regwrite;
  assign alusrca     = cw.alusrca;
  assign iord        = cw.iord;
  assign memtoreg    = cw.memtoreg;
  assign regdst      = cw.regdst;
  assign alusrcb     = cw.alusrcb;
  assign pcsrc       = cw.pcsrc;
  assign state       = state_q;
  // The 16-bit table sits in the low bits; the top two bits are reserved zeros.
  assign controlword = {2'b00, cw};
  assign trap        = (state_q == S_TRAP);
  assign err_code    = err_q;

endmodule

// File: tb/tb_mc_hs_controller.sv
// Directed bench: instance A uses default parameters, instance B has ble disabled
// and a 4-cycle memory timeout.
module tb_mc_hs_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aReset, aZero, aNeg, aMemReady;
  logic [5:0]  aOp, aFunct;
  logic        aMemReq, aPcen, aMemwrite, aIrwrite, aRegwrite, aAlusrca, aIord, aMemtoreg, aRegdst, aTrap;
  logic [1:0]  aAlusrcb, aPcsrc, aErr;
  logic [3:0]  aAlucontrol, aState;
  logic [17:0] aCw;

  logic        bReset, bZero, bNeg, bMemReady;
  logic [5:0]  bOp, bFunct;
  logic        bMemReq, bPcen, bMemwrite, bIrwrite, bRegwrite, bAlusrca, bIord, bMemtoreg, bRegdst, bTrap;
  logic [1:0]  bAlusrcb, bPcsrc, bErr;
  logic [3:0]  bAlucontrol, bState;
  logic [17:0] bCw;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  mc_hs_controller dutA (
    .clk(clk), .reset(aReset), .op(aOp), .funct(aFunct), .zero(aZero), .neg(aNeg),
    .mem_ready(aMemReady), .mem_req(aMemReq), .pcen(aPcen), .memwrite(aMemwrite),
    .irwrite(aIrwrite), .regwrite(aRegwrite), .alusrca(aAlusrca), .iord(aIord),
    .memtoreg(aMemtoreg), .regdst(aRegdst), .alusrcb(aAlusrcb), .pcsrc(aPcsrc),
    .alucontrol(aAlucontrol), .state(aState), .controlword(aCw), .trap(aTrap),
    .err_code(aErr)
  );

  mc_hs_controller #(.EN_BNE(1'b1), .EN_BLE(1'b0), .MEM_TIMEOUT(4), .TO_W(4)) dutB (
    .clk(clk), .reset(bReset), .op(bOp), .funct(bFunct), .zero(bZero), .neg(bNeg),
    .mem_ready(bMemReady), .mem_req(bMemReq), .pcen(bPcen), .memwrite(bMemwrite),
    .irwrite(bIrwrite), .regwrite(bRegwrite), .alusrca(bAlusrca), .iord(bIord),
    .memtoreg(bMemtoreg), .regdst(bRegdst), .alusrcb(bAlusrcb), .pcsrc(bPcsrc),
    .alucontrol(bAlucontrol), .state(bState), .controlword(bCw), .trap(bTrap),
    .err_code(bErr)
  );

  task automatic applyStimulus(input int unit, input logic [5:0] op, input logic [5:0] funct,
                               input logic memReady, input logic zero, input logic neg);
    if (unit == 0) begin
      aOp = op; aFunct = funct; aMemReady = memReady; aZero = zero; aNeg = neg;
    end else begin
      bOp = op; bFunct = funct; bMemReady = memReady; bZero = zero; bNeg = neg;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  initial begin
    logic [3:0] lwStates [5];
    logic       lwWb [5];
    lwStates = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    lwWb     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    aReset = 1'b0;
    bReset = 1'b0;
    applyStimulus(0, 6'b100011, 6'b000000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rstState", aState, 4'd0);
    checkOutput("rstTrap", aTrap, 1'b0);
    checkOutput("rstErr", aErr, 2'b00);
    checkOutput("rstMemReq", aMemReq, 1'b1);
    checkOutput("rstIrwriteGated", aIrwrite, 1'b0);

    // lw with a zero-wait memory
    @(negedge clk);
    aReset = 1'b1;
    applyStimulus(0, 6'b100011, 6'b000000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("lwState%0d", i), aState, lwStates[i]);
      checkOutput($sformatf("lwRegwrite%0d", i), aRegwrite, lwWb[i]);
      checkOutput($sformatf("lwMemtoreg%0d", i), aMemtoreg, lwWb[i]);
      @(negedge clk);
    end

    // FETCH stalled three cycles, then bne
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 6'b000101, 6'b000000, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("fetchWaitState%0d", i), aState, 4'd0);
      checkOutput($sformatf("fetchWaitIrwrite%0d", i), aIrwrite, 1'b0);
      checkOutput($sformatf("fetchWaitPcen%0d", i), aPcen, 1'b0);
      @(negedge clk);
    end
    applyStimulus(0, 6'b000101, 6'b000000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("fetchReadyState", aState, 4'd0);
    checkOutput("fetchReadyIrwrite", aIrwrite, 1'b1);
    checkOutput("fetchReadyPcen", aPcen, 1'b1);
    @(negedge clk); #1;
    checkOutput("bneDecode", aState, 4'd1);
    @(negedge clk); #1;
    checkOutput("bneBrex", aState, 4'd8);
    checkOutput("bneTaken", aPcen, 1'b1);
    checkOutput("bneBrtype", aCw[1:0], 2'b10);
    checkOutput("bneAluSub", aAlucontrol, 4'b0110);
    applyStimulus(0, 6'b000101, 6'b000000, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("bneNotTaken", aPcen, 1'b0);

    // ble
    @(negedge clk);
    applyStimulus(0, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bleFetch", aState, 4'd0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("bleBrex", aState, 4'd8);
    checkOutput("bleNegTaken", aPcen, 1'b1);
    checkOutput("bleBrtype", aCw[1:0], 2'b11);
    applyStimulus(0, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("blePosNotTaken", aPcen, 1'b0);

    // R-type ALU decode
    @(negedge clk);
    applyStimulus(0, 6'b000000, 6'b100101, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("rtypeEx", aState, 4'd6);
    checkOutput("rtypeOr", aAlucontrol, 4'b0001);
    applyStimulus(0, 6'b000000, 6'b101011, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rtypeSltu", aAlucontrol, 4'b1111);
    applyStimulus(0, 6'b000000, 6'b111111, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rtypeUnknown", aAlucontrol, 4'b0010);
    @(negedge clk); #1;
    checkOutput("rtypeWb", aState, 4'd7);
    checkOutput("rtypeWbRegdst", aRegdst, 1'b1);
    checkOutput("rtypeWbRegwrite", aRegwrite, 1'b1);

    // sw, reset asserted during the MEMWR wait
    @(negedge clk);
    applyStimulus(0, 6'b101011, 6'b000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, 6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("swMemwr", aState, 4'd5);
    checkOutput("swWaitMemwrite", aMemwrite, 1'b0);
    applyStimulus(0, 6'b101011, 6'b000000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("swReadyMemwrite", aMemwrite, 1'b1);
    aReset = 1'b0;
    #1;
    checkOutput("midResetMemwrite", aMemwrite, 1'b0);
    checkOutput("midResetState", aState, 4'd0);
    checkOutput("midResetTrap", aTrap, 1'b0);

    // Instance B: ble disabled is illegal
    @(negedge clk);
    bReset = 1'b1;
    applyStimulus(1, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("illFetch", bState, 4'd0);
    @(negedge clk); #1;
    checkOutput("illDecode", bState, 4'd1);
    @(negedge clk); #1;
    checkOutput("illTrapState", bState, 4'd15);
    checkOutput("illTrap", bTrap, 1'b1);
    checkOutput("illErr", bErr, 2'b01);
    checkOutput("illMemReq", bMemReq, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("illHold%0d", i), bState, 4'd15);
    end
    checkOutput("illHoldErr", bErr, 2'b01);
    checkOutput("illHoldPcen", bPcen, 1'b0);
    bReset = 1'b0;
    #1;
    checkOutput("illResetState", bState, 4'd0);
    checkOutput("illResetTrap", bTrap, 1'b0);
    checkOutput("illResetErr", bErr, 2'b00);

    // Instance B: MEMWR never completes, watchdog fires
    @(negedge clk);
    bReset = 1'b1;
    applyStimulus(1, 6'b101011, 6'b000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("toWaitState%0d", i), bState, 4'd5);
      checkOutput($sformatf("toWaitMemwrite%0d", i), bMemwrite, 1'b0);
      @(negedge clk);
    end
    #1;
    checkOutput("toTrapState", bState, 4'd15);
    checkOutput("toTrap", bTrap, 1'b1);
    checkOutput("toErr", bErr, 2'b10);
    checkOutput("toMemwrite", bMemwrite, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
